// File: rtl/prco_seq_ctrl_pkg.sv
// Shared PRCO constants: opcode values, sequencer state encodings and the
// register-writing opcode classification reused by the regfile and benches.
package prco_seq_ctrl_pkg;

    localparam int unsigned PRCO_INSTR_W = 16;
    localparam int unsigned PRCO_OP_W    = 5;
    localparam int unsigned PRCO_IMM_W   = 5;
    localparam int unsigned PRCO_STATE_W = 3;
    localparam int unsigned PRCO_RET_W   = 16;

    localparam logic [PRCO_OP_W-1:0] PRCO_OP_NOP  = 5'd0;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_MOVI = 5'd1;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_MOV  = 5'd2;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_ADD  = 5'd3;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_JMP  = 5'd4;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_HALT = 5'd5;

    typedef enum logic [PRCO_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } prco_state_e;

    // Opcodes that need a register-writeback phase; anything else never writes.
    function automatic logic prco_writes_reg(input logic [PRCO_OP_W-1:0] op);
        return (op == PRCO_OP_MOVI) || (op == PRCO_OP_MOV) || (op == PRCO_OP_ADD);
    endfunction

endpackage

// File: rtl/prco_seq_ctrl.sv
// PRCO multi-cycle sequencer: fetch, decode, execute, writeback; owns the PC,
// jump/halt handling and the retired-instruction counter.
module prco_seq_ctrl
    import prco_seq_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    output logic                    q_mem_req,
    output logic [PC_W-1:0]         q_mem_addr,
    input  logic                    i_mem_rdy,
    input  logic [PRCO_INSTR_W-1:0] i_mem_data,
    output logic [PRCO_INSTR_W-1:0] q_instr,
    output logic                    q_dec_en,
    input  logic [PRCO_OP_W-1:0]    i_op,
    input  logic [PRCO_IMM_W-1:0]   i_simm5,
    output logic                    q_alu_en,
    output logic                    q_reg_we,
    output logic [PC_W-1:0]         q_pc,
    output logic [PRCO_STATE_W-1:0] q_state,
    output logic                    q_halted,
    output logic [PRCO_RET_W-1:0]   q_retired
);

    prco_state_e               state_q;
    prco_state_e               state_d;
    logic [PC_W-1:0]           pc_d;
    logic [PRCO_INSTR_W-1:0]   instr_d;
    logic                      retire;
    logic [PC_W-1:0]           simm_ext;

    assign simm_ext   = {{(PC_W-PRCO_IMM_W){i_simm5[PRCO_IMM_W-1]}}, i_simm5};
    assign q_mem_addr = q_pc;
    assign q_state    = state_q;

    // Next-state, next-PC and retire decision.
    always_comb begin
        state_d = state_q;
        pc_d    = q_pc;
        instr_d = q_instr;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_mem_rdy) begin
                    instr_d = i_mem_data;
                    pc_d    = q_pc + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (prco_writes_reg(i_op)) begin
                    state_d = ST_WB;
                end else if (i_op == PRCO_OP_HALT) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    retire  = 1'b1;
                    state_d = i_en ? ST_FETCH : ST_IDLE;
                    // Offset is relative to the already-incremented PC.
                    if (i_op == PRCO_OP_JMP) pc_d = q_pc + simm_ext;
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = i_en ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath registers and strobes registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            q_pc      <= RESET_PC;
            q_instr   <= '0;
            q_retired <= '0;
            q_mem_req <= 1'b0;
            q_dec_en  <= 1'b0;
            q_alu_en  <= 1'b0;
            q_reg_we  <= 1'b0;
            q_halted  <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_pc      <= pc_d;
            q_instr   <= instr_d;
            if (retire) q_retired <= q_retired + PRCO_RET_W'(1);
            q_mem_req <= (state_d == ST_FETCH);
            q_dec_en  <= (state_d == ST_DECODE);
            q_alu_en  <= (state_d == ST_EXEC);
            q_reg_we  <= (state_d == ST_WB);
            q_halted  <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_prco_seq_ctrl.sv
// Bench for prco_seq_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an instruction-level model.
module tb_prco_seq_ctrl;
    import prco_seq_ctrl_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        q_mem_req;
    logic [15:0] q_mem_addr;
    logic        i_mem_rdy = 1'b0;
    logic [15:0] i_mem_data = 16'h0;
    logic [15:0] q_instr;
    logic        q_dec_en;
    logic [4:0]  i_op = 5'd0;
    logic [4:0]  i_simm5 = 5'd0;
    logic        q_alu_en;
    logic        q_reg_we;
    logic [15:0] q_pc;
    logic [2:0]  q_state;
    logic        q_halted;
    logic [15:0] q_retired;

    int checks = 0;
    int failures = 0;

    prco_seq_ctrl #(.PC_W(16), .RESET_PC(RESET_PC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .q_mem_req(q_mem_req), .q_mem_addr(q_mem_addr),
        .i_mem_rdy(i_mem_rdy), .i_mem_data(i_mem_data),
        .q_instr(q_instr), .q_dec_en(q_dec_en),
        .i_op(i_op), .i_simm5(i_simm5),
        .q_alu_en(q_alu_en), .q_reg_we(q_reg_we),
        .q_pc(q_pc), .q_state(q_state), .q_halted(q_halted),
        .q_retired(q_retired)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in decoder: registers opcode/imm from the latched instruction.
    always @(posedge i_clk) begin
        if (q_dec_en) begin
            i_op    <= q_instr[15:11];
            i_simm5 <= q_instr[4:0];
        end
    end

    // Instruction-level reference model: a pending fetch flag plus a queue of
    // the phases still owed by the in-flight instruction (1=dec, 2=exec, 3=wb).
    bit          m_valid = 0;
    bit          m_fetch = 0;
    bit          m_halted = 0;
    int          m_phase[$];
    logic [15:0] m_pc = 16'h0, m_instr = 16'h0, m_ret = 16'h0;

    function automatic bit model_writes(input logic [4:0] op);
        return op == PRCO_OP_MOVI || op == PRCO_OP_MOV || op == PRCO_OP_ADD;
    endfunction

    always @(posedge i_clk) begin
        int cur;
        logic [4:0] op;
        op = m_instr[15:11];
        if (i_rst) begin
            m_valid = 1; m_fetch = 0; m_halted = 0; m_phase.delete();
            m_pc = RESET_PC; m_instr = 16'h0; m_ret = 16'h0;
        end else if (m_valid && !m_halted) begin
            if (m_fetch) begin
                if (i_mem_rdy) begin
                    m_instr = i_mem_data;
                    m_pc    = m_pc + 16'd1;
                    m_fetch = 0;
                    m_phase = {1, 2};
                    if (model_writes(i_mem_data[15:11])) m_phase.push_back(3);
                end
            end else if (m_phase.size() != 0) begin
                cur = m_phase.pop_front();
                if (cur == 2 && op == PRCO_OP_JMP)
                    m_pc = m_pc + {{11{m_instr[4]}}, m_instr[4:0]};
                if (cur == 2 && op == PRCO_OP_HALT) begin
                    m_halted = 1;
                    m_ret    = m_ret + 16'd1;
                end else if (m_phase.size() == 0) begin
                    m_ret   = m_ret + 16'd1;
                    m_fetch = i_en;
                end
            end else begin
                m_fetch = i_en;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        logic [71:0] act, exp;
        logic [2:0]  st;
        int          cur;
        if (m_valid) begin
            cur = (m_phase.size() != 0) ? m_phase[0] : 0;
            st  = m_halted ? 3'd5 : m_fetch ? 3'd1 : 3'(cur == 0 ? 0 : cur + 1);
            act = {q_mem_req, (q_mem_req ? q_mem_addr : 16'h0), q_instr,
                   q_dec_en, q_alu_en, q_reg_we, q_pc, q_state, q_halted, q_retired};
            exp = {1'(!m_halted && m_fetch), (!m_halted && m_fetch) ? m_pc : 16'h0, m_instr,
                   1'(!m_halted && !m_fetch && cur == 1), 1'(!m_halted && !m_fetch && cur == 2),
                   1'(!m_halted && !m_fetch && cur == 3), m_pc, st, 1'(m_halted), m_ret};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1; i_en = 0; i_mem_rdy = 0;
        @(negedge i_clk);
        i_rst = 0;
    endtask

    // Wait (bounded) for a fetch request, stall `waits` cycles, then deliver d.
    task automatic fetch(input logic [15:0] d, input int waits, output logic [15:0] addr);
        int n = 0;
        while (!q_mem_req && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("fetch_req_seen", 32'(q_mem_req), 32'd1);
        addr = q_mem_addr;
        repeat (waits) @(negedge i_clk);
        i_mem_rdy = 1; i_mem_data = d;
        @(negedge i_clk);
        i_mem_rdy = 0;
    endtask

    function automatic logic [15:0] rand_instr();
        int r = $urandom_range(0, 99);
        logic [4:0] op;
        if      (r < 20) op = PRCO_OP_NOP;
        else if (r < 35) op = PRCO_OP_MOVI;
        else if (r < 50) op = PRCO_OP_MOV;
        else if (r < 65) op = PRCO_OP_ADD;
        else if (r < 85) op = PRCO_OP_JMP;
        else if (r < 96) op = 5'($urandom_range(6, 31));
        else             op = PRCO_OP_HALT;
        return {op, 6'($urandom), 5'($urandom)};
    endfunction

    initial begin
        logic [15:0] a;
        int n, we_n, we_at, req_n, bad;
        int addr_log[3];

        repeat (2) @(negedge i_clk);
        do_reset();
        chk("reset_state", 32'(q_state), 32'd0);
        chk("reset_pc", 32'(q_pc), 32'h0);
        chk("reset_retired", 32'(q_retired), 32'd0);
        chk("reset_strobes", 32'({q_mem_req, q_dec_en, q_alu_en, q_reg_we, q_halted}), 32'd0);

        // NOP stream with zero wait
        i_en = 1; i_mem_rdy = 1; i_mem_data = 16'h0000;
        n = 0; we_n = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge i_clk);
            if (q_mem_req && n < 3) begin addr_log[n] = 32'(q_mem_addr); n++; end
            if (q_reg_we) we_n++;
        end
        chk("nop_fetch_count", 32'(n), 32'd3);
        chk("nop_addr0", 32'(addr_log[0]), 32'd0);
        chk("nop_addr1", 32'(addr_log[1]), 32'd1);
        chk("nop_addr2", 32'(addr_log[2]), 32'd2);
        chk("nop_no_we", 32'(we_n), 32'd0);
        @(negedge i_clk);
        chk("nop_retired3", 32'(q_retired), 32'd3);

        // ADD with two memory wait cycles
        do_reset();
        i_en = 1; i_mem_data = {PRCO_OP_ADD, 11'd0};
        req_n = 0; we_n = 0; we_at = -1; bad = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge i_clk);
            if (c == 1) i_en = 0;
            if (q_mem_req) begin req_n++; if (q_mem_addr != 16'h0) bad++; end
            if (q_reg_we) begin we_n++; we_at = c; end
            if (c == 3) i_mem_rdy = 1;
            if (c == 4) i_mem_rdy = 0;
            if (c == 7) chk("add_end_idle", 32'(q_state), 32'd0);
        end
        chk("add_req_cycles", 32'(req_n), 32'd3);
        chk("add_addr_stable", 32'(bad), 32'd0);
        chk("add_we_once", 32'(we_n), 32'd1);
        chk("add_we_cycle", 32'(we_at), 32'd6);

        // JMP backwards from PC=10, then wrap from 16'hFFF5
        do_reset();
        i_en = 1;
        fetch({PRCO_OP_JMP, 6'd0, 5'b01001}, 0, a);
        fetch({PRCO_OP_JMP, 6'd0, 5'b11110}, 0, a);
        chk("jmp_at_10", 32'(a), 32'd10);
        chk("jmp_pc_inc", 32'(q_pc), 32'd11);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("jmp_back_req", 32'(q_mem_req), 32'd1);
        chk("jmp_back_addr", 32'(q_mem_addr), 32'd9);
        do_reset();
        i_en = 1;
        fetch({PRCO_OP_JMP, 6'd0, 5'b10100}, 0, a);
        fetch({PRCO_OP_JMP, 6'd0, 5'b01111}, 1, a);
        chk("jmp_at_fff5", 32'(a), 32'h0000FFF5);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("jmp_wrap_pc", 32'(q_pc), 32'd5);

        // HALT is sticky until reset
        do_reset();
        i_en = 1;
        fetch({PRCO_OP_HALT, 11'd0}, 0, a);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("halt_flag", 32'(q_halted), 32'd1);
        chk("halt_state", 32'(q_state), 32'd5);
        n = 0;
        repeat (20) begin @(negedge i_clk); if (q_mem_req) n++; end
        chk("halt_no_fetch", 32'(n), 32'd0);
        do_reset();
        chk("halt_rst_pc", 32'(q_pc), 32'(RESET_PC));
        chk("halt_rst_state", 32'(q_state), 32'd0);

        // i_en dropped during DECODE of a MOV
        i_en = 1;
        fetch({PRCO_OP_MOV, 11'h123}, 0, a);
        i_en = 0;
        @(negedge i_clk);
        chk("mov_exec", 32'(q_alu_en), 32'd1);
        @(negedge i_clk);
        chk("mov_wb", 32'(q_reg_we), 32'd1);
        @(negedge i_clk);
        chk("mov_idle", 32'(q_state), 32'd0);
        i_en = 1;
        @(negedge i_clk);
        chk("mov_resume_addr", 32'({q_mem_req, q_mem_addr}), 32'h00010001);
        i_en = 0;
        fetch(16'h0000, 0, a);
        repeat (3) @(negedge i_clk);

        // Reset during a fetch wait, then a stray ready
        do_reset();
        i_en = 1;
        fetch(16'h0000, 0, a);
        repeat (3) @(negedge i_clk);
        chk("rstfetch_pre_ret", 32'(q_retired), 32'd1);
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0; i_en = 0;
        chk("rstfetch_req", 32'(q_mem_req), 32'd0);
        chk("rstfetch_ret", 32'(q_retired), 32'd0);
        i_mem_rdy = 1; i_mem_data = 16'hABCD;
        repeat (3) @(negedge i_clk);
        chk("stray_rdy_instr", 32'(q_instr), 32'd0);
        chk("stray_rdy_state", 32'(q_state), 32'd0);
        i_mem_rdy = 0;

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            @(negedge i_clk);
            i_rst      = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            i_en       = $urandom_range(0, 9) != 0;
            i_mem_rdy  = $urandom_range(0, 2) != 0;
            i_mem_data = rand_instr();
        end
        @(negedge i_clk);
        i_rst = 0; i_en = 0; i_mem_rdy = 0;
        repeat (2) @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prco_seq_ctrl.md
Name: prco_seq_ctrl

Overview:
Multi-cycle sequencer for the PRCO core. It fetches a 16-bit instruction over a request/ready memory handshake and pulses the decoder enable. It then reads back the decoded opcode and steps the execute and register-writeback phases. It owns the program counter, jump handling, halt, and an instruction-retired counter.

Parameters:
PC_W, 16, program counter and memory address width
RESET_PC, 0, PC value loaded on reset

Ports:
i_clk  in  1  core clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  run enable; sampled only at instruction boundaries
q_mem_req  out  1  instruction fetch request
q_mem_addr  out  PC_W  fetch address
i_mem_rdy  in  1  fetch data valid; meaningful only while q_mem_req=1
i_mem_data  in  16  fetched instruction
q_instr  out  16  latched instruction, feeds decoder i_instr
q_dec_en  out  1  decoder enable, one-cycle pulse
i_op  in  5  decoded opcode from decoder q_op
i_simm5  in  5  decoded signed imm5 from decoder q_simm5
q_alu_en  out  1  execute strobe, one-cycle pulse
q_reg_we  out  1  register-file write strobe, one-cycle pulse
q_pc  out  PC_W  current PC
q_state  out  3  current state encoding, for debug
q_halted  out  1  high in HALT
q_retired  out  16  retired-instruction count

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. State, PC, q_instr and q_retired are registers. All strobes are decoded from state.
- Reset (synchronous, overrides everything, including mid-fetch): state=IDLE, q_pc=RESET_PC, q_instr=0, q_retired=0. q_mem_req, q_dec_en, q_alu_en, q_reg_we and q_halted all read 0.
- IDLE: all strobes 0. Goes to FETCH when i_en=1.
- FETCH:
  - q_mem_req=1 and q_mem_addr=q_pc, both held stable until i_mem_rdy=1.
  - On the rdy cycle: q_instr<=i_mem_data, q_pc<=q_pc+1 (wraps mod 2^PC_W), next state DECODE.
  - No timeout; waits indefinitely.
- DECODE: q_dec_en=1 for exactly one cycle. The decoder registers i_op and i_simm5 on this edge. Next state EXEC.
- EXEC: q_alu_en=1 for one cycle. Dispatch on i_op:
  - PRCO_OP_MOVI, PRCO_OP_MOV, PRCO_OP_ADD: next state WB.
  - PRCO_OP_JMP: q_pc<=q_pc+sext(i_simm5), where q_pc is already incremented, so the offset is relative to the next instruction. Mod 2^PC_W. Instruction retires, then boundary rule applies.
  - PRCO_OP_HALT: next state HALT; instruction retires.
  - PRCO_OP_NOP and unknown opcodes: instruction retires, then boundary rule applies. Unknown opcodes never write.
- WB: q_reg_we=1 for one cycle; instruction retires, then boundary rule applies.
- Boundary rule: the next state is FETCH if i_en=1, else IDLE. Deasserting i_en mid-instruction never aborts that instruction.
- Retire: q_retired+1 (wraps 16'hFFFF to 0) on the last cycle of each instruction: EXEC for non-writing ops, WB for writing ops.
- HALT: q_halted=1, all other strobes 0. Only i_rst exits.
- Latency with zero memory wait: 4 cycles for writing ops, 3 cycles otherwise. Each memory wait cycle adds 1.
- At most one of q_mem_req, q_dec_en, q_alu_en, q_reg_we is high in any cycle.
- If i_mem_rdy=1 while q_mem_req=0, it is ignored.

Decomposition:
- Add PRCO_OP_JMP and PRCO_OP_HALT opcode defines to the shared ISA include, alongside the existing opcodes.
- The state encodings and the PRCO_WRITES_REG(op) classification macro live in the shared constants include, so the regfile and bench can reuse them.
- No sub-module; the next-PC adder is inline.

Test Plan:
- Reset then i_en=1, with mem returning 16'h0000 (NOP) and rdy high every cycle -> q_mem_addr sequence 0,1,2; one fetch every 3 cycles; q_retired=3 after 9 cycles; q_reg_we never high.
- ADD instruction, rdy delayed 2 cycles -> q_mem_req held 3 cycles with q_mem_addr constant; q_reg_we pulses exactly once, 3 cycles after the rdy cycle; total 6 cycles.
- JMP with simm5=5'b11110 fetched at PC=10 -> q_pc goes 11, then 9; next q_mem_addr=9. JMP with simm5=5'b01111 at PC=16'hFFF5 -> q_pc=5 (wrap).
- HALT fetched -> q_halted=1 and state 5; no further q_mem_req for 20 cycles even with i_en=1; i_rst -> q_pc=RESET_PC, IDLE.
- i_en dropped during DECODE of a MOV -> EXEC then WB still occur, q_reg_we pulses, then state IDLE; re-raising i_en resumes fetch at the saved q_pc.
- i_rst asserted during FETCH wait -> q_mem_req=0 the next cycle and q_retired=0; a stray i_mem_rdy afterwards latches nothing.
